hdmi_period_scheduler: RTL and testbench

- Per-pixel-clock sequencer that selects which TMDS period each lane carries: control, video preamble/guard, active video, or data island (preamble, guards, packets).
- Sits upstream of the TMDS/TERC4 encoders and the three 10:1 lane serializers.
- Delays the incoming video timing to make room for preambles and guard bands.
- Issues a packet handshake to the packet source.

---
 rtl/hdmi_period_scheduler.sv | 270 +++++++++++++++++++++++++++
 tb/tb_hdmi_period_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_period_scheduler.sv
// HDMI TMDS period sequencer: control, video preamble/guard, active video and data islands.
// Data islands exist only when DATA_ISLAND_EN is defined; otherwise the block runs in DVI mode.
module hdmi_period_scheduler #(
   parameter int unsigned MAX_PACKETS = 2,
   parameter int unsigned CNT_W       = 12
) (
   input  logic       pixel_clock,
   input  logic       reset,
   input  logic       de_in,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic       pkt_req,
   output logic [2:0] period,
   output logic [3:0] ctl,
   output logic       hsync_out,
   output logic       vsync_out,
   output logic       pkt_ack,
   output logic [4:0] pkt_phase,
   output logic       di_first,
   output logic       pkt_abort
);
   localparam int unsigned DLY   = 11;
   localparam int unsigned CNT5W = 5;

   typedef enum logic [2:0] {
      S_CTRL        = 3'd0,
      S_VID_PRE     = 3'd1,
      S_VID_GB      = 3'd2,
      S_VID         = 3'd3,
      S_DI_PRE      = 3'd4,
      S_DI_GB_LEAD  = 3'd5,
      S_DI_DATA     = 3'd6,
      S_DI_GB_TRAIL = 3'd7
   } period_t;

   period_t          r_state;
   period_t          w_state_nxt;
   logic [CNT5W-1:0] r_cnt;
   logic [CNT5W-1:0] w_cnt_nxt;
   logic [DLY-1:0]   r_de_dly;
   logic [DLY-1:0]   r_hs_dly;
   logic [DLY-1:0]   r_vs_dly;
   logic [3:0]       r_ctl;
   logic [3:0]       w_ctl_nxt;
   logic             r_hsync_out;
   logic             r_vsync_out;
   logic             w_de_dly;
   logic             w_rise;

   assign w_de_dly = r_de_dly[DLY-1];
   // Rise seen one stage into the line so VID_PRE lands on the cycle after the source edge
   assign w_rise   = r_de_dly[0] & ~r_de_dly[1];

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         r_de_dly <= '0;
         r_hs_dly <= '0;
         r_vs_dly <= '0;
      end else begin
         r_de_dly <= {r_de_dly[DLY-2:0], de_in};
         r_hs_dly <= {r_hs_dly[DLY-2:0], hsync_in};
         r_vs_dly <= {r_vs_dly[DLY-2:0], vsync_in};
      end
   end

`ifdef DATA_ISLAND_EN
   localparam int unsigned PKT_W      = 3;
   localparam int unsigned RUN_W      = 4;
   localparam int unsigned CTRL_MIN   = 12;
   localparam int unsigned ISLAND_MIN = 66;
   localparam int unsigned EXTEND_MIN = 56;

   logic [PKT_W-1:0] r_pkts;
   logic [PKT_W-1:0] w_pkts_nxt;
   logic [RUN_W-1:0] r_ctrl_run;
   logic [CNT_W-1:0] r_elapsed;
   logic [CNT_W-1:0] r_prev_len;
   logic [CNT_W-1:0] w_remaining;
   logic             r_de_prev;
   logic             r_seen_fall;
   logic             r_pkt_ack;
   logic [4:0]       r_pkt_phase;
   logic             r_di_first;
   logic             r_pkt_abort;
   logic             w_in_island;
   logic             w_start;
   logic             w_extend;

   // Blanking length measured on the delayed (output-aligned) de
   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         r_elapsed   <= '0;
         r_prev_len  <= '0;
         r_de_prev   <= 1'b0;
         r_seen_fall <= 1'b0;
      end else begin
         r_de_prev <= w_de_dly;
         if (w_de_dly) begin
            r_elapsed <= '0;
            if (!r_de_prev && r_seen_fall)
               r_prev_len <= r_elapsed;
         end else begin
            if (r_de_prev)
               r_seen_fall <= 1'b1;
            if (r_elapsed != '1)
               r_elapsed <= r_elapsed + CNT_W'(1);
         end
      end
   end

   // A saturated measurement means "long": never limits an island
   always_comb begin
      w_remaining = '0;
      if (r_prev_len == '1)
         w_remaining = '1;
      else if (r_prev_len > r_elapsed)
         w_remaining = r_prev_len - r_elapsed;
   end

   assign w_in_island = (r_state == S_DI_PRE) || (r_state == S_DI_GB_LEAD) ||
                        (r_state == S_DI_DATA) || (r_state == S_DI_GB_TRAIL);
   assign w_start  = pkt_req && (r_ctrl_run >= RUN_W'(CTRL_MIN)) &&
                     (w_remaining >= CNT_W'(ISLAND_MIN));
   assign w_extend = pkt_req && (r_pkts < PKT_W'(MAX_PACKETS)) &&
                     (w_remaining >= CNT_W'(EXTEND_MIN));
`else
   logic w_unused_ok;
   assign w_unused_ok = pkt_req ^ (CNT_W == 32'd0) ^ (MAX_PACKETS == 32'd0);
`endif

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         r_state <= S_CTRL;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next period; a source de rise pre-empts every state
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT5W'(1);
`ifdef DATA_ISLAND_EN
      w_pkts_nxt  = r_pkts;
`endif
      if (w_rise) begin
         w_state_nxt = S_VID_PRE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            S_CTRL: begin
               w_cnt_nxt = '0;
`ifdef DATA_ISLAND_EN
               if (w_start) w_state_nxt = S_DI_PRE;
`endif
            end
            S_VID_PRE: begin
               if (r_cnt == CNT5W'(7)) begin
                  w_state_nxt = S_VID_GB;
                  w_cnt_nxt   = '0;
               end
            end
            S_VID_GB: begin
               if (r_cnt == CNT5W'(1)) begin
                  w_cnt_nxt = '0;
                  if (w_de_dly) w_state_nxt = S_VID;
                  else          w_state_nxt = S_CTRL;
               end
            end
            S_VID: begin
               w_cnt_nxt = '0;
               if (!w_de_dly) w_state_nxt = S_CTRL;
            end
`ifdef DATA_ISLAND_EN
            S_DI_PRE: begin
               if (r_cnt == CNT5W'(7)) begin
                  w_state_nxt = S_DI_GB_LEAD;
                  w_cnt_nxt   = '0;
               end
            end
            S_DI_GB_LEAD: begin
               if (r_cnt == CNT5W'(1)) begin
                  w_state_nxt = S_DI_DATA;
                  w_cnt_nxt   = '0;
                  w_pkts_nxt  = PKT_W'(1);
               end
            end
            S_DI_DATA: begin
               if (r_cnt == CNT5W'(31)) begin
                  w_cnt_nxt = '0;
                  if (w_extend) w_pkts_nxt  = r_pkts + PKT_W'(1);
                  else          w_state_nxt = S_DI_GB_TRAIL;
               end
            end
            S_DI_GB_TRAIL: begin
               if (r_cnt == CNT5W'(1)) begin
                  w_state_nxt = S_CTRL;
                  w_cnt_nxt   = '0;
               end
            end
`endif
            default: begin
               w_state_nxt = S_CTRL;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_comb begin
      w_ctl_nxt = 4'b0000;
      if (w_state_nxt == S_VID_PRE)
         w_ctl_nxt = 4'b0001;
      else if (w_state_nxt == S_DI_PRE)
         w_ctl_nxt = 4'b0101;
   end

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         r_ctl       <= '0;
         r_hsync_out <= 1'b0;
         r_vsync_out <= 1'b0;
      end else begin
         r_ctl       <= w_ctl_nxt;
         r_hsync_out <= r_hs_dly[DLY-1];
         r_vsync_out <= r_vs_dly[DLY-1];
      end
   end

`ifdef DATA_ISLAND_EN
   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         r_pkts      <= '0;
         r_ctrl_run  <= '0;
         r_pkt_ack   <= 1'b0;
         r_pkt_phase <= '0;
         r_di_first  <= 1'b0;
         r_pkt_abort <= 1'b0;
      end else begin
         r_pkts      <= w_pkts_nxt;
         if (w_state_nxt != S_CTRL)
            r_ctrl_run <= '0;
         else if (r_ctrl_run != '1)
            r_ctrl_run <= r_ctrl_run + RUN_W'(1);
         r_pkt_ack   <= (w_state_nxt == S_DI_DATA) && (w_cnt_nxt == '0);
         r_pkt_phase <= (w_state_nxt == S_DI_DATA) ? w_cnt_nxt : '0;
         r_di_first  <= (w_state_nxt == S_DI_DATA) && (r_state == S_DI_GB_LEAD);
         r_pkt_abort <= w_rise && w_in_island;
      end
   end

   assign pkt_ack   = r_pkt_ack;
   assign pkt_phase = r_pkt_phase;
   assign di_first  = r_di_first;
   assign pkt_abort = r_pkt_abort;
`else
   assign pkt_ack   = 1'b0;
   assign pkt_phase = 5'd0;
   assign di_first  = 1'b0;
   assign pkt_abort = 1'b0;
`endif

   assign period    = r_state;
   assign ctl       = r_ctl;
   assign hsync_out = r_hsync_out;
   assign vsync_out = r_vsync_out;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Bench for hdmi_period_scheduler: directed lines plus random lines, every output
// checked each cycle against a timeline model built from source history.
module tb_hdmi_period_scheduler;
   localparam int MAXP = 2;
   localparam int NCYC = 20000;
`ifdef DATA_ISLAND_EN
   localparam int DI_EN = 1;
`else
   localparam int DI_EN = 0;
`endif

   logic       pixel_clock = 1'b0;
   logic       reset;
   logic       de_in, hsync_in, vsync_in, pkt_req;
   logic [2:0] period;
   logic [3:0] ctl;
   logic       hsync_out, vsync_out, pkt_ack, di_first, pkt_abort;
   logic [4:0] pkt_phase;

   hdmi_period_scheduler #(.MAX_PACKETS(MAXP), .CNT_W(12)) dut (
      .pixel_clock(pixel_clock), .reset(reset), .de_in(de_in), .hsync_in(hsync_in),
      .vsync_in(vsync_in), .pkt_req(pkt_req), .period(period), .ctl(ctl),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .pkt_ack(pkt_ack),
      .pkt_phase(pkt_phase), .di_first(di_first), .pkt_abort(pkt_abort)
   );

   always #5 pixel_clock = ~pixel_clock;

   int n_pass = 0, n_fail = 0, n_total = 0;
   int k = 0;
   bit de_h[NCYC], hs_h[NCYC], vs_h[NCYC], req_h[NCYC];

   // Reference timeline state
   int last_rise = -100000;
   int m_elapsed = 0, m_prev = 0, m_run = 0;
   bit m_seen = 0, m_dde_prev = 0;
   bit isl_active = 0;
   int isl_start = 0, isl_npk = 0, isl_trail = -1;
   int n_ack = 0, n_abort = 0, n_first = 0;

   function automatic bit de_at(input int i);
      if (i < 1) return 1'b0;
      return de_h[i];
   endfunction
   function automatic bit hs_at(input int i);
      if (i < 1) return 1'b0;
      return hs_h[i];
   endfunction
   function automatic bit vs_at(input int i);
      if (i < 1) return 1'b0;
      return vs_h[i];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, k, obs, exp);
      end
   endtask

   task automatic model_check();
      int  dv, o, e_period, e_phase, rem;
      bit  rise, dd, e_ack, e_first, e_abort;
      logic [3:0] e_ctl;
      rise = de_at(k-1) && !de_at(k-2);
      if (rise) last_rise = k - 1;
      dv   = k - last_rise;
      dd   = de_at(k-11);
      rem  = (m_prev == 4095) ? 4095 : ((m_prev > m_elapsed) ? m_prev - m_elapsed : 0);
      e_phase = 0; e_ack = 0; e_first = 0; e_abort = 0;
      if (dv >= 1 && dv <= 8)        e_period = 1;
      else if (dv == 9 || dv == 10)  e_period = 2;
      else if (dd && dv >= 11)       e_period = 3;
      else                           e_period = 0;

      if (rise) begin
         if (isl_active) e_abort = 1;
         isl_active = 0;
      end else if (isl_active) begin
         o = k - isl_start;
         if (o < 8) e_period = 4;
         else if (o < 10) e_period = 5;
         else if (isl_trail < 0 && o < 10 + 32*isl_npk) begin
            e_period = 6;
            e_phase  = (o - 10) % 32;
         end else if (isl_trail < 0 && req_h[k] && isl_npk < MAXP && rem >= 56) begin
            isl_npk++;
            e_period = 6;
            e_phase  = 0;
         end else begin
            if (isl_trail < 0) isl_trail = o;
            if (o < isl_trail + 2) e_period = 7;
            else begin
               e_period   = 0;
               isl_active = 0;
            end
         end
         e_ack   = (e_period == 6) && (e_phase == 0);
         e_first = (e_period == 6) && (o == 10);
      end else if (DI_EN != 0 && m_run >= 12 && req_h[k] && rem >= 66) begin
         isl_active = 1;
         isl_start  = k;
         isl_npk    = 1;
         isl_trail  = -1;
         e_period   = 4;
      end

      e_ctl = (e_period == 1) ? 4'b0001 : ((e_period == 4) ? 4'b0101 : 4'b0000);
      chk("period",    32'(period),    32'(e_period));
      chk("ctl",       32'(ctl),       32'(e_ctl));
      chk("hsync_out", 32'(hsync_out), 32'(hs_at(k-11)));
      chk("vsync_out", 32'(vsync_out), 32'(vs_at(k-11)));
      chk("pkt_ack",   32'(pkt_ack),   32'(e_ack));
      chk("pkt_phase", 32'(pkt_phase), 32'(e_phase));
      chk("di_first",  32'(di_first),  32'(e_first));
      chk("pkt_abort", 32'(pkt_abort), 32'(e_abort));

      if (dd) begin
         if (!m_dde_prev && m_seen) m_prev = m_elapsed;
         m_elapsed = 0;
      end else begin
         if (m_dde_prev) m_seen = 1;
         if (m_elapsed < 4095) m_elapsed++;
      end
      m_dde_prev = dd;
      m_run = (e_period == 0) ? m_run + 1 : 0;
   endtask

   task automatic step(input bit de, input bit hs, input bit vs, input bit req);
      if (k >= NCYC - 1) begin
         $display("FAIL cycle_budget cycle=%0d observed=overrun expected=<%0d", k, NCYC);
         $fatal(1, "cycle budget exceeded");
      end
      de_in = de; hsync_in = hs; vsync_in = vs; pkt_req = req;
      k++;
      de_h[k] = de; hs_h[k] = hs; vs_h[k] = vs; req_h[k] = req;
      @(posedge pixel_clock);
      #1;
      n_ack   += int'(pkt_ack);
      n_abort += int'(pkt_abort);
      n_first += int'(di_first);
      model_check();
   endtask

   // mode 0: pkt_req low, 1: held high, 2: random toggling
   task automatic line(input int act, input int blk, input int mode);
      bit req;
      req = (mode != 0);
      for (int i = 0; i < act + blk; i++) begin
         if (mode == 2 && $urandom_range(7, 0) == 0) req = !req;
         step(i < act, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), req);
      end
   endtask

   initial begin
      reset = 1'b1; de_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; pkt_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         de_in = ~de_in;
         @(posedge pixel_clock);
         #1;
      end
      chk("rst_period",    32'(period),    32'd0);
      chk("rst_ctl",       32'(ctl),       32'd0);
      chk("rst_hsync",     32'(hsync_out), 32'd0);
      chk("rst_vsync",     32'(vsync_out), 32'd0);
      chk("rst_pkt_ack",   32'(pkt_ack),   32'd0);
      chk("rst_pkt_phase", 32'(pkt_phase), 32'd0);
      chk("rst_di_first",  32'(di_first),  32'd0);
      chk("rst_pkt_abort", 32'(pkt_abort), 32'd0);
      reset = 1'b0;

      // First line after reset: nothing measured yet, so no island
      for (int i = 0; i < 99; i++) step(1'b0, 1'($urandom_range(1, 0)), 1'b0, 1'b1);
      line(120, 200, 1);
      chk("first_line_acks", 32'(n_ack), 32'd0);

      // Measured blanking of 200: full two-packet island
      n_ack = 0; n_first = 0;
      line(120, 200, 1);
      chk("island_acks",  32'(n_ack),   32'(2 * DI_EN));
      chk("island_first", 32'(n_first), 32'(DI_EN));

      // Blanking cut to 60 while the island runs, then a 60 measurement suppresses islands
      n_abort = 0;
      line(120, 60, 1);
      line(120, 60, 1);
      chk("abort_count", 32'(n_abort), 32'(DI_EN));
      n_ack = 0;
      line(120, 60, 1);
      line(120, 200, 1);
      chk("short_blank_acks", 32'(n_ack), 32'd0);

      for (int ln = 0; ln < 25; ln++) begin
         int act, blk, mode;
         act  = $urandom_range(150, 20);
         blk  = $urandom_range(260, 30);
         mode = $urandom_range(2, 0);
         line(act, blk, mode);
      end
      line(0, 40, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
